// File: rtl/gray_codec_if.sv
// Bus bundle for gray_codec: encode and decode paths plus the optional step flag.
// gray_step_err is present only when GRAY_CODEC_STEP_CHECK_EN is defined.
interface gray_codec_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] binary_in;
    logic [WIDTH-1:0] gray_comb;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] binary_comb;
    logic [WIDTH-1:0] binary_out;
`ifdef GRAY_CODEC_STEP_CHECK_EN
    logic             gray_step_err;
`endif

    modport master (
        output binary_in,
        output gray_in,
        input  gray_comb,
        input  gray_out,
        input  binary_comb,
`ifdef GRAY_CODEC_STEP_CHECK_EN
        input  gray_step_err,
`endif
        input  binary_out
    );

    modport slave (
        input  binary_in,
        input  gray_in,
        output gray_comb,
        output gray_out,
        output binary_comb,
`ifdef GRAY_CODEC_STEP_CHECK_EN
        output gray_step_err,
`endif
        output binary_out
    );
endinterface

// File: rtl/gray_codec.sv
// Registered bidirectional Gray codec (binary->Gray and Gray->binary).
// Define GRAY_CODEC_STEP_CHECK_EN to add a multi-bit-step checker on gray_in.
module gray_codec #(
    parameter int WIDTH = 8
) (
    input logic          clock,
    input logic          resetn,
    gray_codec_if.slave  bus
);
    logic [WIDTH-1:0] gray_c;
    logic [WIDTH-1:0] bin_c;
    logic [WIDTH-1:0] gray_out_d,   gray_out_q;
    logic [WIDTH-1:0] binary_out_d, binary_out_q;

    always_comb begin
        gray_c = bus.binary_in ^ (bus.binary_in >> 1);
    end

    // Each binary bit is the XOR reduction of the Gray bits at and above it.
    always_comb begin
        bin_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin_c[i] = ^(bus.gray_in >> i);
        end
    end

    always_comb begin
        gray_out_d   = gray_c;
        binary_out_d = bin_c;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gray_out_q   <= '0;
            binary_out_q <= '0;
        end else begin
            gray_out_q   <= gray_out_d;
            binary_out_q <= binary_out_d;
        end
    end

    assign bus.gray_comb   = gray_c;
    assign bus.binary_comb = bin_c;
    assign bus.gray_out    = gray_out_q;
    assign bus.binary_out  = binary_out_q;

`ifdef GRAY_CODEC_STEP_CHECK_EN
    logic [WIDTH-1:0] gray_prev_d, gray_prev_q;
    logic             hist_valid_d, hist_valid_q;
    logic             step_err_d, step_err_q;

    // Holds and single-bit changes are legal; the first sample after reset is never checked.
    always_comb begin
        gray_prev_d  = bus.gray_in;
        hist_valid_d = 1'b1;
        step_err_d   = hist_valid_q && ($countones(bus.gray_in ^ gray_prev_q) > 1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gray_prev_q  <= '0;
            hist_valid_q <= 1'b0;
            step_err_q   <= 1'b0;
        end else begin
            gray_prev_q  <= gray_prev_d;
            hist_valid_q <= hist_valid_d;
            step_err_q   <= step_err_d;
        end
    end

    assign bus.gray_step_err = step_err_q;
`endif
endmodule

// File: tb/tb_gray_codec.sv
// Directed self-checking bench for gray_codec (WIDTH=8); step-checker cases
// are compiled in when GRAY_CODEC_STEP_CHECK_EN is defined.
module tb_gray_codec;
    logic clock;
    logic resetn;
    int   total;
    int   bad;

    gray_codec_if #(.WIDTH(8)) bus ();

    gray_codec #(.WIDTH(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] vv;
    logic [7:0] exp_g;
    logic [7:0] prev_g;

    initial begin
        total         = 0;
        bad           = 0;
        resetn        = 1'b0;
        bus.binary_in = 8'h00;
        bus.gray_in   = 8'h00;

        // Reset state and live combinational paths during reset
        #2;
        check("rst_gray_out", {24'd0, bus.gray_out}, 32'h00);
        check("rst_binary_out", {24'd0, bus.binary_out}, 32'h00);
        bus.binary_in = 8'h05;
        bus.gray_in   = 8'h80;
        #1;
        check("comb_enc_05", {24'd0, bus.gray_comb}, 32'h07);
        check("comb_dec_80", {24'd0, bus.binary_comb}, 32'hFF);
        after_edge();
        check("rst_hold_gray_out", {24'd0, bus.gray_out}, 32'h00);
        check("rst_hold_binary_out", {24'd0, bus.binary_out}, 32'h00);

        // Release between edges; first capture at the following rising edge
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("rel_gray_out_pre", {24'd0, bus.gray_out}, 32'h00);
        after_edge();
        check("lat_gray_out_05", {24'd0, bus.gray_out}, 32'h07);
        check("lat_binary_out_80", {24'd0, bus.binary_out}, 32'hFF);

        @(negedge clock);
        bus.binary_in = 8'hFF;
        bus.gray_in   = 8'h07;
        #1;
        check("comb_enc_ff", {24'd0, bus.gray_comb}, 32'h80);
        check("comb_dec_07", {24'd0, bus.binary_comb}, 32'h05);
        check("lat_gray_out_prev", {24'd0, bus.gray_out}, 32'h07);
        check("lat_binary_out_prev", {24'd0, bus.binary_out}, 32'hFF);
        after_edge();
        check("lat_gray_out_ff", {24'd0, bus.gray_out}, 32'h80);
        check("lat_binary_out_07", {24'd0, bus.binary_out}, 32'h05);

        // Exhaustive sweep 0..255 then wrap to 0, loopback gray_comb -> gray_in
        prev_g = 8'h00;
        for (int v = 0; v <= 256; v++) begin
            @(negedge clock);
            vv = v[7:0];
            bus.binary_in = vv;
            #1;
            exp_g = vv ^ {1'b0, vv[7:1]};
            check("sweep_enc", {24'd0, bus.gray_comb}, {24'd0, exp_g});
            bus.gray_in = bus.gray_comb;
            #1;
            check("sweep_roundtrip", {24'd0, bus.binary_comb}, {24'd0, vv});
            if (v > 0)
                check("sweep_onebit", $countones(bus.gray_comb ^ prev_g), 32'd1);
            prev_g = bus.gray_comb;
            after_edge();
            check("sweep_gray_out", {24'd0, bus.gray_out}, {24'd0, exp_g});
            check("sweep_binary_out", {24'd0, bus.binary_out}, {24'd0, vv});
`ifdef GRAY_CODEC_STEP_CHECK_EN
            if (v > 0)
                check("sweep_step_err", {31'd0, bus.gray_step_err}, 32'd0);
`endif
        end

        // Reset asserted mid-stream between edges
        @(negedge clock);
        bus.binary_in = 8'h05;
        bus.gray_in   = 8'h07;
        after_edge();
        check("pre_mid_gray_out", {24'd0, bus.gray_out}, 32'h07);
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_gray_out", {24'd0, bus.gray_out}, 32'h00);
        check("mid_rst_binary_out", {24'd0, bus.binary_out}, 32'h00);
        after_edge();
        check("mid_rst_hold_gray", {24'd0, bus.gray_out}, 32'h00);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("mid_rel_hold_gray", {24'd0, bus.gray_out}, 32'h00);
        check("mid_rel_hold_bin", {24'd0, bus.binary_out}, 32'h00);
        after_edge();
        check("mid_rel_gray_out", {24'd0, bus.gray_out}, 32'h07);
        check("mid_rel_binary_out", {24'd0, bus.binary_out}, 32'h05);

`ifdef GRAY_CODEC_STEP_CHECK_EN
        // Step checker: fresh reset, then F0 (first, unchecked), 00, 01, 01, 07, 07
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("step_rst_err", {31'd0, bus.gray_step_err}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        bus.gray_in = 8'hF0;
        after_edge();
        check("step_first_sample", {31'd0, bus.gray_step_err}, 32'd0);
        @(negedge clock); bus.gray_in = 8'h00;
        after_edge();
        check("step_f0_00", {31'd0, bus.gray_step_err}, 32'd1);
        @(negedge clock); bus.gray_in = 8'h01;
        after_edge();
        check("step_00_01", {31'd0, bus.gray_step_err}, 32'd0);
        @(negedge clock); bus.gray_in = 8'h01;
        after_edge();
        check("step_01_01", {31'd0, bus.gray_step_err}, 32'd0);
        @(negedge clock); bus.gray_in = 8'h07;
        after_edge();
        check("step_01_07", {31'd0, bus.gray_step_err}, 32'd1);
        @(negedge clock); bus.gray_in = 8'h07;
        after_edge();
        check("step_not_sticky", {31'd0, bus.gray_step_err}, 32'd0);
`endif

        // Random runs of 32 consecutive values, wrap-around included
        for (int s = 0; s < 32; s++) begin
            int start;
            start = (s == 0) ? 240 : int'($urandom_range(0, 255));
            for (int k = 0; k < 32; k++) begin
                int t;
                t = (start + k) % 256;
                @(negedge clock);
                vv = t[7:0];
                bus.binary_in = vv;
                #1;
                bus.gray_in = bus.gray_comb;
                #1;
                check("rand_roundtrip", {24'd0, bus.binary_comb}, {24'd0, vv});
                if (k > 0)
                    check("rand_onebit", $countones(bus.gray_comb ^ prev_g), 32'd1);
                prev_g = bus.gray_comb;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
